// File: rtl/axi4_burst_sequencer_if.sv
// Command/status and master-side handshake bundle for the burst sequencer.
// The sequencer connects through 'slave'; the commanding side (and the master model) through 'master'.
interface axi4_burst_sequencer_if #(
  parameter int ADDR_W  = 32,
  parameter int COUNT_W = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_address;
  logic [COUNT_W-1:0] cmd_burst_count;
  logic               busy;
  logic               done;
  logic               error;
  logic [COUNT_W-1:0] bursts_completed;
  logic [ADDR_W-1:0]  write_address;
  logic               write_start;
  logic               write_end;
  logic [ADDR_W-1:0]  read_address;
  logic               read_start;
  logic               read_end;
  logic               master_idle;
  logic               master_error;

  modport slave (
    input  cmd_valid, cmd_write, cmd_address, cmd_burst_count,
           write_end, read_end, master_idle, master_error,
    output cmd_ready, busy, done, error, bursts_completed,
           write_address, write_start, read_address, read_start
  );

  modport master (
    output cmd_valid, cmd_write, cmd_address, cmd_burst_count,
           write_end, read_end, master_idle, master_error,
    input  cmd_ready, busy, done, error, bursts_completed,
           write_address, write_start, read_address, read_start
  );
endinterface

// File: rtl/axi4_burst_sequencer.sv
// Splits one command into successive single-burst start pulses to an AXI4 master,
// stepping the address one burst at a time, with sticky error and stall watchdog.
module axi4_burst_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 256,
  parameter int C_COUNT_WIDTH      = 16,
  parameter int C_TIMEOUT_CYCLES   = 0
) (
  input  logic                         M_AXI_ACLK,
  input  logic                         M_AXI_ARESETN,
  axi4_burst_sequencer_if.slave        bus
);
  localparam int AW          = C_M_AXI_ADDR_WIDTH;
  localparam int CW          = C_COUNT_WIDTH;
  localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
  localparam logic [AW-1:0] BURST_INC = AW'(BURST_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t        state, state_n;
  logic          dir;
  logic [AW-1:0] addr;
  logic [CW-1:0] remaining;
  logic [31:0]   wd_cnt;

  logic accept, load, misalign, issue, burst_end, last_burst, abort, wd_hit, end_sel;

  assign end_sel    = dir ? bus.write_end : bus.read_end;
  assign last_burst = (remaining == CW'(1));
  assign wd_hit     = (C_TIMEOUT_CYCLES != 0) && (wd_cnt == 32'(C_TIMEOUT_CYCLES - 1));

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= S_IDLE;
    else                state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    load      = 1'b0;
    misalign  = 1'b0;
    issue     = 1'b0;
    burst_end = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (bus.cmd_burst_count == '0)
            state_n = S_DONE;
          else if ((bus.cmd_address % BURST_INC) != '0)
            misalign = 1'b1;
          else begin
            load    = 1'b1;
            state_n = S_START;
          end
        end
      end
      S_START: begin
        if (bus.master_error) begin
          abort   = 1'b1;
          state_n = S_IDLE;
        end else if (bus.master_idle) begin
          issue   = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // An error or timeout in the same cycle as an end pulse discards that burst.
        if (bus.master_error || wd_hit) begin
          abort   = 1'b1;
          state_n = S_IDLE;
        end else if (end_sel) begin
          burst_end = 1'b1;
          state_n   = last_burst ? S_DONE : S_START;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      dir                  <= 1'b0;
      addr                 <= '0;
      remaining            <= '0;
      wd_cnt               <= '0;
      bus.error            <= 1'b0;
      bus.bursts_completed <= '0;
      bus.write_start      <= 1'b0;
      bus.read_start       <= 1'b0;
      bus.write_address    <= '0;
      bus.read_address     <= '0;
    end else begin
      bus.write_start <= 1'b0;
      bus.read_start  <= 1'b0;

      if (accept) begin
        bus.error            <= misalign;
        bus.bursts_completed <= '0;
      end
      if (abort) bus.error <= 1'b1;

      if (load) begin
        dir       <= bus.cmd_write;
        addr      <= bus.cmd_address;
        remaining <= bus.cmd_burst_count;
      end

      if (issue) begin
        wd_cnt <= '0;
        if (dir) begin
          bus.write_start   <= 1'b1;
          bus.write_address <= addr;
        end else begin
          bus.read_start    <= 1'b1;
          bus.read_address  <= addr;
        end
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 32'd1;
      end

      if (burst_end) begin
        bus.bursts_completed <= bus.bursts_completed + CW'(1);
        if (!last_burst) begin
          remaining <= remaining - CW'(1);
          addr      <= addr + BURST_INC;
        end
      end
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_axi4_burst_sequencer.sv
// Directed bench: expected start/done events go into a scoreboard queue as each
// command is issued; a negedge monitor pops and compares whenever the DUT emits one.
module tb_axi4_burst_sequencer;
  localparam int AW = 32;
  localparam int CW = 16;

  typedef struct {
    int            kind;   // 0 write_start, 1 read_start, 2 done
    logic [AW-1:0] addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];

  axi4_burst_sequencer_if #(.ADDR_W(AW), .COUNT_W(CW)) bus ();

  axi4_burst_sequencer #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_BURST_LEN (4),
    .C_COUNT_WIDTH     (CW),
    .C_TIMEOUT_CYCLES  (8)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [AW-1:0] addr);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input logic [AW-1:0] addr);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h expected none", kind, addr);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== addr) begin
        fails++;
        $display("FAIL event_order: got kind %0d addr 0x%0h expected kind %0d addr 0x%0h",
                 kind, addr, e.kind, e.addr);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.write_start) pop_chk(0, bus.write_address);
      if (bus.read_start)  pop_chk(1, bus.read_address);
      if (bus.done)        pop_chk(2, '0);
    end
  end

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [CW-1:0] n);
    @(negedge clk);
    bus.cmd_valid       = 1'b1;
    bus.cmd_write       = w;
    bus.cmd_address     = a;
    bus.cmd_burst_count = n;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.write_start || bus.read_start) && k < 40);
    chk({name, "_start_seen"}, {31'd0, bus.write_start | bus.read_start}, 32'd1);
  endtask

  task automatic pulse(input logic we, input logic re, input logic me);
    @(negedge clk);
    bus.write_end    = we;
    bus.read_end     = re;
    bus.master_error = me;
    @(negedge clk);
    bus.write_end    = 1'b0;
    bus.read_end     = 1'b0;
    bus.master_error = 1'b0;
  endtask

  initial begin
    int k;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0; bus.cmd_burst_count = '0;
    bus.write_end = 1'b0; bus.read_end = 1'b0; bus.master_idle = 1'b1; bus.master_error = 1'b0;

    #12;
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_error", {31'd0, bus.error}, 32'd0);
    chk("rst_bursts", 32'(bus.bursts_completed), 32'd0);
    chk("rst_starts", {30'd0, bus.write_start, bus.read_start}, 32'd0);
    chk("rst_addr", bus.write_address | bus.read_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three write bursts, 16 bytes each
    push(0, 32'h100); push(0, 32'h110); push(0, 32'h120); push(2, '0);
    send_cmd(1'b1, 32'h100, 16'd3);
    for (int i = 0; i < 3; i++) begin
      wait_start("t1");
      pulse(1'b1, 1'b0, 1'b0);
    end
    chk("t1_done_now", {31'd0, bus.done}, 32'd1);
    chk("t1_bursts", 32'(bus.bursts_completed), 32'd3);
    chk("t1_error", {31'd0, bus.error}, 32'd0);
    @(negedge clk);
    chk("t1_idle", {31'd0, bus.cmd_ready}, 32'd1);

    // 2: read with address wrap; stray write_end ignored
    push(1, 32'hFFFF_FFF0); push(1, 32'h0000_0000); push(2, '0);
    send_cmd(1'b0, 32'hFFFF_FFF0, 16'd2);
    wait_start("t2a");
    pulse(1'b1, 1'b0, 1'b0);
    chk("t2_wend_ignored", 32'(bus.bursts_completed), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    wait_start("t2b");
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("t2_bursts", 32'(bus.bursts_completed), 32'd2);
    chk("t2_error", {31'd0, bus.error}, 32'd0);
    @(negedge clk);

    // 3: zero-count command
    push(2, '0);
    send_cmd(1'b1, 32'h40, 16'd0);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.busy) k++;
      @(negedge clk);
    end
    chk("t3_busy_cycles", 32'(k), 32'd1);
    chk("t3_bursts", 32'(bus.bursts_completed), 32'd0);

    // 4: misaligned address, then next command clears error
    send_cmd(1'b1, 32'h104, 16'd1);
    chk("t4_error", {31'd0, bus.error}, 32'd1);
    chk("t4_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("t4_busy", {31'd0, bus.busy}, 32'd0);
    repeat (4) @(negedge clk);
    push(2, '0);
    send_cmd(1'b0, 32'h0, 16'd0);
    chk("t4_error_cleared", {31'd0, bus.error}, 32'd0);
    repeat (2) @(negedge clk);

    // 5a: watchdog fires on the withheld second burst
    push(0, 32'h200); push(0, 32'h210);
    send_cmd(1'b1, 32'h200, 16'd2);
    wait_start("t5a");
    pulse(1'b1, 1'b0, 1'b0);
    wait_start("t5a2");
    k = 0;
    while (!bus.error && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5a_wd_cycles", 32'(k), 32'd8);
    chk("t5a_bursts", 32'(bus.bursts_completed), 32'd1);
    chk("t5a_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);

    // 5b: master_error coincident with second write_end; that burst not counted
    push(0, 32'h300); push(0, 32'h310);
    send_cmd(1'b1, 32'h300, 16'd3);
    wait_start("t5b");
    pulse(1'b1, 1'b0, 1'b0);
    wait_start("t5b2");
    pulse(1'b1, 1'b0, 1'b1);
    chk("t5b_error", {31'd0, bus.error}, 32'd1);
    chk("t5b_bursts", 32'(bus.bursts_completed), 32'd1);
    chk("t5b_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);

    // 6: start gated by master_idle, then async reset in WAIT
    bus.master_idle = 1'b0;
    push(0, 32'h400);
    send_cmd(1'b1, 32'h400, 16'd1);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.write_start || bus.read_start) k++;
    end
    chk("t6_no_start_while_busy_master", 32'(k), 32'd0);
    bus.master_idle = 1'b1;
    wait_start("t6");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_start", {31'd0, bus.write_start}, 32'd0);
    chk("t6_rst_addr", bus.write_address, 32'd0);
    chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("t6_rst_error", {31'd0, bus.error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
